// File: rtl/regfile_pkg.sv
// Shared constants and requester ids for the register-bank writeback path.
package regfile_pkg;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous writeback queue of {addr,data}; every slot's valid/addr is
// exported so the arbiter can build the pending-write scoreboard.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 64,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH-1:0]         ent_vld,
    output logic [DEPTH-1:0][AW-1:0] ent_addr
);
    logic [DEPTH-1:0][AW-1:0] mem_addr;
    logic [DEPTH-1:0][DW-1:0] mem_data;
    logic [PW-1:0]            rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        nxt = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign ent_addr  = mem_addr;

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [PW-1:0] off;
        assign off        = PW'(i) - rd_ptr;
        assign ent_vld[i] = (CW'(off) < count);
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of the ALU (A) and mult/div (B) writeback queues onto the
// single register-bank write port, plus the RAW pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREGS  = regfile_pkg::NREGS,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [NREGS-1:0]  we,
    output logic [DATA_W-1:0] wdata,
    output logic              wgrant_b,
    output logic [NREGS-1:0]  pending
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                         a_push, b_push, a_pop, b_pop;
    logic                         a_full, b_full, a_empty, b_empty;
    logic [CW-1:0]                a_count, b_count;
    logic [ADDR_W-1:0]            a_head_addr, b_head_addr;
    logic [DATA_W-1:0]            a_head_data, b_head_data;
    logic [DEPTH-1:0]             a_vld, b_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] a_ent_addr, b_ent_addr;
    logic                         unused_cnt;
    req_id_e                      last;

    // Register 0 and out-of-range addresses decode to no enable at all.
    function automatic logic [NREGS-1:0] dec(input logic [ADDR_W-1:0] a);
        dec = '0;
        for (int i = 1; i < NREGS; i++)
            if (int'(a) == i) dec[i] = 1'b1;
    endfunction

    assign a_ready    = !a_full;
    assign b_ready    = !b_full;
    assign a_push     = a_valid && a_ready;
    assign b_push     = b_valid && b_ready;
    assign unused_cnt = ^{a_count, b_count};

    wb_fifo #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_qa (
        .clock(clock), .reset(reset),
        .push(a_push), .push_addr(a_addr), .push_data(a_data),
        .pop(a_pop), .head_addr(a_head_addr), .head_data(a_head_data),
        .count(a_count), .full(a_full), .empty(a_empty),
        .ent_vld(a_vld), .ent_addr(a_ent_addr)
    );

    wb_fifo #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_qb (
        .clock(clock), .reset(reset),
        .push(b_push), .push_addr(b_addr), .push_data(b_data),
        .pop(b_pop), .head_addr(b_head_addr), .head_data(b_head_data),
        .count(b_count), .full(b_full), .empty(b_empty),
        .ent_vld(b_vld), .ent_addr(b_ent_addr)
    );

    always_comb begin
        a_pop = 1'b0;
        b_pop = 1'b0;
        if (!a_empty && !b_empty) begin
            if (last == REQ_A) b_pop = 1'b1;
            else               a_pop = 1'b1;
        end else if (!a_empty) begin
            a_pop = 1'b1;
        end else if (!b_empty) begin
            b_pop = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we       <= '0;
            wdata    <= '0;
            wgrant_b <= 1'b0;
            last     <= REQ_B;
        end else if (a_pop || b_pop) begin
            we       <= dec(b_pop ? b_head_addr : a_head_addr);
            wdata    <= b_pop ? b_head_data : a_head_data;
            wgrant_b <= b_pop;
            last     <= b_pop ? REQ_B : REQ_A;
        end else begin
            we <= '0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_vld[i]) pending = pending | dec(a_ent_addr[i]);
            if (b_vld[i]) pending = pending | dec(b_ent_addr[i]);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: accepted writes are queued per
// requester and matched against every asserted we.
module tb_regfile_wb_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic [31:0] we, pending;
    logic [63:0] wdata;
    logic        wgrant_b;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t        sb_a[$], sb_b[$];
    logic        gseq[$];
    logic [63:0] hist7[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we(we), .wdata(wdata), .wgrant_b(wgrant_b), .pending(pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic reset_dut();
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset   = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // Capture accepted writes; register 0 and out-of-range never reach we.
    always @(posedge clock) begin
        if (reset) begin
            sb_a.delete();
            sb_b.delete();
        end else begin
            if (a_valid && a_ready && a_addr != 5'd0) sb_a.push_back('{a_addr, a_data});
            if (b_valid && b_ready && b_addr != 5'd0) sb_b.push_back('{b_addr, b_data});
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && we != 32'd0) begin
            chk("we_onehot", 64'($onehot(we)), 64'd1);
            gseq.push_back(wgrant_b);
            if (we[7]) hist7.push_back(wdata);
            if ((wgrant_b ? sb_b.size() : sb_a.size()) == 0) begin
                chk("spurious_we", {32'd0, we}, 64'd0);
            end else begin
                e = wgrant_b ? sb_b.pop_front() : sb_a.pop_front();
                chk(wgrant_b ? "wb_addr_b" : "wb_addr_a", {32'd0, we}, {32'd0, 32'd1 << e.addr});
                chk(wgrant_b ? "wb_data_b" : "wb_data_a", wdata, e.data);
            end
        end
    end

    initial begin
        int na, nb, lowa;
        bit acc_a, acc_b;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
        reset_dut();

        for (int i = 0; i < 10; i++) begin
            chk("idle_we", {32'd0, we}, 64'd0);
            chk("idle_wdata", wdata, 64'd0);
            chk("idle_pending", {32'd0, pending}, 64'd0);
            chk("idle_a_ready", {63'd0, a_ready}, 64'd1);
            chk("idle_b_ready", {63'd0, b_ready}, 64'd1);
            idle(1);
        end

        // single A write
        a_valid = 1'b1; a_addr = 5'd5; a_data = 64'hDEAD_BEEF_0000_0001;
        idle(1);
        a_valid = 1'b0;
        chk("single_pending_set", {32'd0, pending}, 64'h20);
        chk("single_we_not_yet", {32'd0, we}, 64'd0);
        idle(1);
        chk("single_we", {32'd0, we}, 64'h20);
        chk("single_wdata", wdata, 64'hDEAD_BEEF_0000_0001);
        chk("single_grant_b", {63'd0, wgrant_b}, 64'd0);
        chk("single_pending_clr", {32'd0, pending}, 64'd0);
        idle(3);

        // both requesters streaming from a fresh reset
        reset_dut();
        gseq.delete();
        na = 0; nb = 0; lowa = 0;
        for (int cyc = 0; cyc < 100 && (na < 8 || nb < 8); cyc++) begin
            a_valid = (na < 8); a_addr = 5'(1 + na % 4);  a_data = 64'hA000 + 64'(na);
            b_valid = (nb < 8); b_addr = 5'(11 + nb % 4); b_data = 64'hB000 + 64'(nb);
            if (!a_ready) lowa++;
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            idle(1);
            if (acc_a) na++;
            if (acc_b) nb++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("stream_sent", 64'(na + nb), 64'd16);
        chk("stream_a_backpressure", 64'(lowa > 0), 64'd1);
        idle(12);
        chk("stream_grants", 64'(gseq.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            if (gseq.size() > i) chk("grant_order", {63'd0, gseq[i]}, 64'(i % 2));
        chk("stream_sb_a_drained", 64'(sb_a.size()), 64'd0);
        chk("stream_sb_b_drained", 64'(sb_b.size()), 64'd0);

        // same register from both sides; last grant was B so A goes first
        hist7.delete();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 64'd1;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 64'd2;
        idle(1);
        a_valid = 1'b0; b_valid = 1'b0;
        idle(4);
        chk("r7_writes", 64'(hist7.size()), 64'd2);
        if (hist7.size() == 2) begin
            chk("r7_first", hist7[0], 64'd1);
            chk("r7_final", hist7[1], 64'd2);
        end

        // write to register 0 is swallowed, next entry follows
        a_valid = 1'b1; a_addr = 5'd0; a_data = 64'hFF;
        idle(1);
        chk("r0_pending", {32'd0, pending}, 64'd0);
        a_addr = 5'd9; a_data = 64'h99;
        idle(1);
        a_valid = 1'b0;
        chk("r0_we", {32'd0, we}, 64'd0);
        chk("r0_next_pending", {32'd0, pending}, 64'h200);
        idle(1);
        chk("r0_next_we", {32'd0, we}, 64'h200);
        chk("r0_next_wdata", wdata, 64'h99);
        idle(3);

        // reset with both queues loaded
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_addr = 5'(20 + k); a_data = 64'hC0 + 64'(k);
            b_valid = 1'b1; b_addr = 5'(25 + k); b_data = 64'hD0 + 64'(k);
            idle(1);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("flush_loaded_a", {63'd0, a_ready}, 64'd0);
        chk("flush_pending_nz", 64'(pending != 32'd0), 64'd1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("flush_we", {32'd0, we}, 64'd0);
        chk("flush_pending", {32'd0, pending}, 64'd0);
        chk("flush_a_ready", {63'd0, a_ready}, 64'd1);
        chk("flush_b_ready", {63'd0, b_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("flush_idle_we", {32'd0, we}, 64'd0);
            idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
